regfile_read_stage: RTL
=======================

// Module: regfile_read_stage
// PURPOSE
//   RV32I integer register file plus registered operand-read stage. It is the
//   receiving end of the writeback write port (we / rd_out / data_out) and
//   delivers rs1/rs2 operands to execute one cycle after a read request.
//   It resolves same-cycle write/read hazards by bypassing writeback data, and
//   it keeps held operands coherent with writebacks that arrive during a stall.
// PARAMETERS
//   width     32   data width of each architectural register
//   NREGS     32   number of architectural registers; x0 is hardwired to 0
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   wb_we      in   1      write enable from writeback
//   wb_rd      in   5      destination register index from writeback
//   wb_data    in   width  write data from writeback
//   re         in   1      read request; rs1/rs2 are sampled this cycle
//   hold       in   1      stall: freeze the read stage (execute not ready)
//   rs1        in   5      source register index 1
//   rs2        in   5      source register index 2
//   rs1_data   out  width  registered operand 1
//   rs2_data   out  width  registered operand 2
//   rd_valid   out  1      rs1_data/rs2_data carry a valid read result
// BEHAVIOUR
// - Reset (rst=1 at posedge): regs x1..x31 <= 0; rs1_data, rs2_data <= 0;
//   rd_valid <= 0; held indices <= 0.
//   - Reset overrides any write or read in the same cycle.
// - Write: at posedge, if wb_we=1 and wb_rd!=0, then regs[wb_rd] <= wb_data.
//   - A write to x0 is discarded.
// - Read, when hold=0, at posedge:
//   - rd_valid <= re.
//   - If re=1, latch rs1/rs2 into idx1_q/idx2_q and load each operand:
//     - index==0                  -> 0
//     - wb_we=1 && wb_rd==index   -> wb_data (bypass; wins over array value)
//     - otherwise                 -> regs[index]
//   - If re=0, rs1_data/rs2_data keep their values; only rd_valid drops to 0.
//   - Latency from re to data is exactly 1 cycle; throughput is 1 read/cycle.
// - Hold (hold=1): rd_valid, idx1_q and idx2_q are unchanged; re, rs1 and rs2
//   are ignored.
//   - If wb_we=1, wb_rd!=0 and wb_rd==idx1_q, then rs1_data <= wb_data
//     (same rule for idx2_q / rs2_data).
//   - Otherwise the operands hold their values.
//   - This keeps stalled operands current with late writebacks.
// - Both ports may name the same register; each gets an identical value.
// - Write and bypass happen in the same cycle. The next-cycle read of the same
//   index sees the array value, which equals the bypassed value.
// - No combinational path from any input to any output.
// TESTING
//   1 wb_we=1,wb_rd=5,wb_data=0xDEADBEEF; next cycle re=1,rs1=5
//     -> one cycle later rs1_data=0xDEADBEEF, rd_valid=1
//   2 same cycle: wb_we=1,wb_rd=7,wb_data=0x12345678 and re=1,rs1=7,rs2=7
//     -> next cycle rs1_data=rs2_data=0x12345678 (bypass)
//   3 wb_we=1,wb_rd=0,wb_data=0xFFFFFFFF; then re=1,rs1=0 -> rs1_data=0
//   4 re=1,rs2=9 (x9=0x11) then hold=1; during hold wb_we=1,wb_rd=9,data=0x22
//     -> rs2_data becomes 0x22 next cycle, rd_valid stays 1
//   5 write x3=0xAA, then assert rst with wb_we=1,wb_rd=3,data=0xBB and re=1
//     -> outputs 0, rd_valid=0; subsequent read of x3 returns 0
//   6 back-to-back re=1 for rs1=1..31 after writing regs[i]=i
//     -> rs1_data=i on each following cycle, rd_valid continuously 1

Source files
------------

// File: rtl/regfile_read_stage.sv
// RV32I integer register file with a registered, bypassed operand-read stage.
// Held operands track writebacks that land while execute is stalled.
module regfile_read_stage #(
   parameter int width = 32,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_we,
   input  logic [4:0]       wb_rd,
   input  logic [width-1:0] wb_data,
   input  logic             re,
   input  logic             hold,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic [width-1:0] rs1_data,
   output logic [width-1:0] rs2_data,
   output logic             rd_valid
);

   logic [width-1:0] regs_q [NREGS];

   logic             wb_write;
   logic [width-1:0] rd1_val;
   logic [width-1:0] rd2_val;

   logic [width-1:0] rs1_q, rs1_d;
   logic [width-1:0] rs2_q, rs2_d;
   logic [4:0]       idx1_q, idx1_d;
   logic [4:0]       idx2_q, idx2_d;
   logic             valid_q, valid_d;

   // x0 is never written, so the array entry for it stays at its reset value.
   assign wb_write = wb_we && (wb_rd != 5'd0);

   // NOTE: the array is cleared on reset because software may read any
   //       register before writing it and must observe zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_write) begin
         regs_q[wb_rd] <= wb_data;
      end
   end

   // Bypass forwards the in-flight writeback over the stale array entry.
   always_comb begin
      rd1_val = regs_q[rs1];
      if (rs1 == 5'd0) begin
         rd1_val = '0;
      end else if (wb_we && (wb_rd == rs1)) begin
         rd1_val = wb_data;
      end

      rd2_val = regs_q[rs2];
      if (rs2 == 5'd0) begin
         rd2_val = '0;
      end else if (wb_we && (wb_rd == rs2)) begin
         rd2_val = wb_data;
      end
   end

   // NOTE: every _d gets its _q as a default first, so no path through this
   //       block leaves a variable unassigned and no latch is inferred.
   always_comb begin
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      idx1_d  = idx1_q;
      idx2_d  = idx2_q;
      valid_d = valid_q;

      if (hold) begin
         if (wb_write && (wb_rd == idx1_q)) begin
            rs1_d = wb_data;
         end
         if (wb_write && (wb_rd == idx2_q)) begin
            rs2_d = wb_data;
         end
      end else begin
         valid_d = re;
         if (re) begin
            idx1_d = rs1;
            idx2_d = rs2;
            rs1_d  = rd1_val;
            rs2_d  = rd2_val;
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every register
   //       samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rs1_q   <= '0;
         rs2_q   <= '0;
         idx1_q  <= '0;
         idx2_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         idx1_q  <= idx1_d;
         idx2_q  <= idx2_d;
         valid_q <= valid_d;
      end
   end

   assign rs1_data = rs1_q;
   assign rs2_data = rs2_q;
   assign rd_valid = valid_q;

endmodule
